// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the single-precision mantissa add/normalise slice:
// field widths, the controller state encoding and the packed result word.
// No ports (package).
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int MANT_W = 24;                  // mantissa incl. hidden bit
  localparam int EXP_W  = 8;
  localparam int FRAC_W = MANT_W - 1;          // stored fraction bits
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  // IEEE-754 single layout, MSB first.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_word_t;

  function automatic fp_word_t pack_fp(input logic              sign,
                                       input logic [EXP_W-1:0]  exp,
                                       input logic [FRAC_W-1:0] frac);
    fp_word_t w;
    w.sign = sign;
    w.exp  = exp;
    w.frac = frac;
    return w;
  endfunction

endpackage

// File: rtl/mant_addnorm_if.sv
// -----------------------------------------------------------------------------
// mant_addnorm_if
// Operand/result handshake bundle for mant_addnorm.
//   in_valid/in_ready        : operand handshake
//   shifted_val              : aligned smaller mantissa (hidden bit included)
//   nonshifted_val           : larger mantissa (hidden bit included)
//   exponent_temp            : exponent of the larger operand
//   sel                      : 1 = operand 1 is the larger operand
//   sign1, sign2, op         : operand signs, 0 = add / 1 = subtract
//   out_valid/out_ready      : result handshake
//   result, overflow, underflow : packed IEEE-754 single result and flags
// Modports: master = operand producer / result consumer, slave = the block.
// -----------------------------------------------------------------------------
interface mant_addnorm_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] shifted_val;
  logic [MANT_W-1:0] nonshifted_val;
  logic [EXP_W-1:0]  exponent_temp;
  logic              sel;
  logic              sign1;
  logic              sign2;
  logic              op;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              overflow;
  logic              underflow;

  modport master (
    output in_valid, shifted_val, nonshifted_val, exponent_temp,
           sel, sign1, sign2, op, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, shifted_val, nonshifted_val, exponent_temp,
           sel, sign1, sign2, op, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );

endinterface

// File: rtl/mant_addsub.sv
// -----------------------------------------------------------------------------
// mant_addsub
// 25-bit mantissa adder/subtractor. The extra MSB carries the add overflow;
// the subtract path assumes A >= B so it never borrows.
//   A   : larger mantissa (24 bits)
//   B   : aligned smaller mantissa (24 bits)
//   sub : 1 = A - B, 0 = A + B
//   S   : 25-bit result
// -----------------------------------------------------------------------------
module mant_addsub
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] A,
  input  logic [MANT_W-1:0] B,
  input  logic              sub,
  output logic [MANT_W:0]   S
);

  always_comb begin
    if (sub) S = {1'b0, A} - {1'b0, B};
    else     S = {1'b0, A} + {1'b0, B};
  end

endmodule

// File: rtl/mant_addnorm.sv
// -----------------------------------------------------------------------------
// mant_addnorm
// Adds or subtracts two pre-aligned single-precision mantissas, normalises the
// sum one bit per cycle and packs an IEEE-754 single result (truncation only,
// denormal inputs unsupported).
//   clk   : clock, all state on the rising edge
//   rstn  : synchronous reset, active high (1 = reset)
//   bus   : mant_addnorm_if.slave operand/result handshake
// Parameter FLUSH_UNDERFLOW: 1 = an underflowed result becomes signed zero,
// 0 = the partially normalised fraction is emitted with exponent 0.
// Flow: IDLE -> ADD -> (NORM)* -> DONE -> IDLE.
// -----------------------------------------------------------------------------
module mant_addnorm
  import fp_pkg::*;
#(
  parameter bit FLUSH_UNDERFLOW = 1'b1
)(
  input  logic          clk,
  input  logic          rstn,
  mant_addnorm_if.slave bus
);

  // ---------------------------------------------------------------------------
  // State and datapath registers (_q) with their next values (_n)
  // ---------------------------------------------------------------------------
  state_t            state_q,  state_n;
  logic [MANT_W-1:0] small_q,  small_n;   // aligned smaller mantissa
  logic [MANT_W-1:0] large_q,  large_n;   // larger mantissa
  logic [EXP_W-1:0]  exp_q,    exp_n;
  logic              sign_q,   sign_n;    // sign of the result
  logic              sub_q,    sub_n;     // effective subtract
  logic [MANT_W-1:0] mant_q,   mant_n;    // mantissa being normalised
  fp_word_t          result_q, result_n;
  logic              ovf_q,    ovf_n;
  logic              unf_q,    unf_n;

  // ---------------------------------------------------------------------------
  // Mantissa add/subtract
  // ---------------------------------------------------------------------------
  logic [MANT_W:0] sum;

  mant_addsub u_addsub (
    .A   (large_q),
    .B   (small_q),
    .sub (sub_q),
    .S   (sum)
  );

  // Helpers for the ADD carry case and the NORM shift step.
  logic [EXP_W-1:0]  exp_inc;
  logic [EXP_W-1:0]  exp_dec;
  logic [MANT_W-1:0] mant_shl;

  assign exp_inc  = exp_q + 8'd1;
  assign exp_dec  = exp_q - 8'd1;
  assign mant_shl = {mant_q[MANT_W-2:0], 1'b0};

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_n  = state_q;
    small_n  = small_q;
    large_n  = large_q;
    exp_n    = exp_q;
    sign_n   = sign_q;
    sub_n    = sub_q;
    mant_n   = mant_q;
    result_n = result_q;
    ovf_n    = ovf_q;
    unf_n    = unf_q;

    unique case (state_q)
      IDLE: begin
        // in_ready is 1 throughout IDLE outside reset, and reset overrides
        // these values in the register block, so in_valid alone means accept.
        if (bus.in_valid) begin
          small_n = bus.shifted_val;
          large_n = bus.nonshifted_val;
          exp_n   = bus.exponent_temp;
          sign_n  = bus.sel ? bus.sign1 : (bus.sign2 ^ bus.op);
          sub_n   = bus.sign1 ^ bus.sign2 ^ bus.op;
          mant_n  = '0;
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          state_n = ADD;
        end
      end

      ADD: begin
        if (sum == '0) begin
          // Exact cancellation always yields positive zero.
          result_n = '0;
          state_n  = DONE;
        end else if (sum[MANT_W]) begin
          // Carry out: drop the LSB and bump the exponent.
          mant_n = sum[MANT_W:1];
          exp_n  = exp_inc;
          if (exp_inc == EXP_MAX) begin
            result_n = pack_fp(sign_q, EXP_MAX, '0);
            ovf_n    = 1'b1;
          end else begin
            result_n = pack_fp(sign_q, exp_inc, sum[MANT_W-1:1]);
          end
          state_n = DONE;
        end else if (sum[MANT_W-1]) begin
          // Already normalised.
          mant_n   = sum[MANT_W-1:0];
          result_n = pack_fp(sign_q, exp_q, sum[FRAC_W-1:0]);
          state_n  = DONE;
        end else begin
          mant_n  = sum[MANT_W-1:0];
          state_n = NORM;
        end
      end

      NORM: begin
        if (exp_q == 8'd1) begin
          // No further shift possible without a zero exponent.
          unf_n = 1'b1;
          if (FLUSH_UNDERFLOW) result_n = pack_fp(sign_q, '0, '0);
          else                 result_n = pack_fp(sign_q, '0, mant_q[FRAC_W-1:0]);
          state_n = DONE;
        end else begin
          mant_n = mant_shl;
          exp_n  = exp_dec;
          if (mant_shl[MANT_W-1]) begin
            result_n = pack_fp(sign_q, exp_dec, mant_shl[FRAC_W-1:0]);
            state_n  = DONE;
          end
        end
      end

      DONE: begin
        // Result and flags hold until the consumer takes them.
        if (bus.out_ready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    if (rstn) begin
      state_q  <= IDLE;
      small_q  <= '0;
      large_q  <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      mant_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      small_q  <= small_n;
      large_q  <= large_n;
      exp_q    <= exp_n;
      sign_q   <= sign_n;
      sub_q    <= sub_n;
      mant_q   <= mant_n;
      result_q <= result_n;
      ovf_q    <= ovf_n;
      unf_q    <= unf_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // in_ready is gated by rstn so it stays low for the whole reset, including
  // the cycles after the first reset edge has already forced IDLE.
  assign bus.in_ready  = (state_q == IDLE) && !rstn;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_mant_addnorm.sv
// -----------------------------------------------------------------------------
// tb_mant_addnorm
// Scoreboard bench for mant_addnorm: the driver pushes the expected response
// of each accepted operation; a monitor compares whenever out_valid is high.
// -----------------------------------------------------------------------------
module tb_mant_addnorm;

  localparam bit FLUSH = 1'b1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;   // accept edge to first edge sampling out_valid
    int          acc;   // cycle index of the accept edge
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   hold_ready = 1'b0;
  bit   seen = 1'b0;
  exp_t sbq[$];

  mant_addnorm_if bus ();

  mant_addnorm #(.FLUSH_UNDERFLOW(FLUSH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Reference model: plain arithmetic on the operand values.
  function automatic exp_t model(input logic [23:0] ns, input logic [23:0] sh,
                                 input logic [7:0] e, input logic s1, input logic s2,
                                 input logic sl, input logic o);
    exp_t        m;
    logic [31:0] sum;
    logic [31:0] norm;
    logic        sgn;
    int          p, n, k, ei;
    ei    = int'(e);
    sgn   = sl ? s1 : (s2 ^ o);
    sum   = (s1 ^ s2 ^ o) ? 32'(ns) - 32'(sh) : 32'(ns) + 32'(sh);
    m.ovf = 1'b0;
    m.unf = 1'b0;
    m.lat = 2;
    m.acc = 0;
    if (sum == 0) begin
      m.res = 32'h0;
      return m;
    end
    p = 0;
    for (int i = 0; i < 25; i++) if (sum[i]) p = i;
    if (p == 24) begin
      if (ei + 1 >= 255) begin
        m.res = {sgn, 8'hFF, 23'h0};
        m.ovf = 1'b1;
      end else begin
        m.res = {sgn, 8'(ei + 1), sum[23:1]};
      end
    end else begin
      n = 23 - p;
      if (n <= ei - 1) begin
        norm  = sum << n;
        m.res = {sgn, 8'(ei - n), norm[22:0]};
        m.lat = 2 + n;
      end else begin
        k     = ei - 1;
        norm  = sum << k;
        m.unf = 1'b1;
        m.lat = 2 + k + 1;
        m.res = FLUSH ? {sgn, 31'h0} : {sgn, 8'h00, norm[22:0]};
      end
    end
    return m;
  endfunction

  // Monitor: choose out_ready for the coming edge, then compare.
  always @(negedge clk) begin
    bus.out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (rstn) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got out_valid=1 result=0x%08h, expected no output", bus.result);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 32'(cyc + 1 - sbq[0].acc), 32'(sbq[0].lat));
        end
        check("result", bus.result, sbq[0].res);
        check("overflow", 32'(bus.overflow), 32'(sbq[0].ovf));
        check("underflow", 32'(bus.underflow), 32'(sbq[0].unf));
        if (bus.out_ready) begin
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [23:0] ns, input logic [23:0] sh, input logic [7:0] e,
                      input logic s1, input logic s2, input logic sl, input logic o,
                      input exp_t ex);
    int w = 0;
    @(negedge clk);
    bus.nonshifted_val = ns;
    bus.shifted_val    = sh;
    bus.exponent_temp  = e;
    bus.sign1          = s1;
    bus.sign2          = s2;
    bus.sel            = sl;
    bus.op             = o;
    bus.in_valid       = 1'b1;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", w);
      bus.in_valid = 1'b0;
      return;
    end
    ex.acc = cyc + 1;
    sbq.push_back(ex);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [23:0] ns, input logic [23:0] sh, input logic [7:0] e,
                       input logic s1, input logic s2, input logic sl, input logic o);
    send(ns, sh, e, s1, s2, sl, o, model(ns, sh, e, s1, s2, sl, o));
  endtask

  task automatic issue_dir(input logic [23:0] ns, input logic [23:0] sh, input logic [7:0] e,
                           input logic s1, input logic s2, input logic sl, input logic o,
                           input logic [31:0] res, input logic ovf, input logic unf, input int lat);
    exp_t ex;
    ex.res = res;
    ex.ovf = ovf;
    ex.unf = unf;
    ex.lat = lat;
    ex.acc = 0;
    send(ns, sh, e, s1, s2, sl, o, ex);
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic [23:0] ns, sh;
    logic [7:0]  e;
    int          w;

    rstn               = 1'b1;
    bus.in_valid       = 1'b0;
    bus.shifted_val    = '0;
    bus.nonshifted_val = '0;
    bus.exponent_temp  = '0;
    bus.sel            = 1'b0;
    bus.sign1          = 1'b0;
    bus.sign2          = 1'b0;
    bus.op             = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
    rstn = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Directed cases.
    issue_dir(24'h800000, 24'h800000, 8'd127, 0, 0, 1, 0, 32'h40000000, 0, 0, 2);
    issue_dir(24'hC00000, 24'h800000, 8'd127, 0, 0, 1, 1, 32'h3F000000, 0, 0, 3);
    issue_dir(24'h800000, 24'h800000, 8'd130, 0, 0, 1, 1, 32'h00000000, 0, 0, 2);
    issue_dir(24'hFFFFFF, 24'hFFFFFF, 8'd254, 0, 0, 1, 0, 32'h7F800000, 1, 0, 2);
    issue_dir(24'h800000, 24'h7FFFFF, 8'd1,   0, 0, 1, 1, 32'h00000000, 0, 1, 3);
    issue_dir(24'h800000, 24'h800000, 8'd127, 1, 1, 1, 0, 32'hC0000000, 0, 0, 2);
    issue_dir(24'hC00000, 24'h800000, 8'd127, 0, 0, 0, 1, 32'hBF000000, 0, 0, 3);
    drain();

    // Backpressure: result must hold while out_ready stays low.
    hold_ready = 1'b1;
    issue_dir(24'h800000, 24'h800000, 8'd127, 0, 0, 1, 0, 32'h40000000, 0, 0, 2);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    hold_ready = 1'b0;
    drain();

    // Reset during NORM: sum of 1 needs 23 shifts.
    issue(24'h800000, 24'h7FFFFF, 8'd100, 0, 0, 1, 1);
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    sbq.delete();
    repeat (2) @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_result", bus.result, 32'h0);
    rstn = 1'b0;
    #1;
    check("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
    repeat (30) @(negedge clk);
    check("midrst_no_output", 32'(bus.out_valid), 32'd0);

    // Randomized operations.
    for (int t = 0; t < 300; t++) begin
      ns = {1'b1, 23'($urandom)};
      case ($urandom_range(0, 3))
        0:       sh = ns >> $urandom_range(0, 24);
        1:       sh = ns - 24'($urandom_range(0, 64));
        2:       sh = 24'($urandom_range(0, int'(ns)));
        default: sh = ns;
      endcase
      w = $urandom_range(0, 9);
      if (w < 2)       e = 8'($urandom_range(1, 4));
      else if (w == 2) e = 8'($urandom_range(250, 254));
      else             e = 8'($urandom_range(1, 254));
      issue(ns, sh, e, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mant_addnorm.md
MANT_ADDNORM -- requirements
Module: mant_addnorm

Interface
REQ-001 SHALL have parameter FLUSH_UNDERFLOW, default 1, meaning an underflowed result is replaced by signed zero.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  synchronous, active-high reset (1 = reset).
REQ-004 SHALL have port in_valid  input  1  aligned operands present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port shifted_val  input  24  aligned smaller mantissa (hidden bit included).
REQ-007 SHALL have port nonshifted_val  input  24  larger mantissa (hidden bit included).
REQ-008 SHALL have port exponent_temp  input  8  exponent of the larger operand.
REQ-009 SHALL have port sel  input  1  1 = operand 1 is the larger operand.
REQ-010 SHALL have ports sign1, sign2  input  1 each  operand signs.
REQ-011 SHALL have port op  input  1  0 = add, 1 = subtract (operand1 - operand2).
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port result  output  32  IEEE-754 single result {sign, exp[7:0], frac[22:0]}.
REQ-015 SHALL have ports overflow, underflow  output  1 each  exception flags, valid with out_valid.

Function
REQ-016 SHALL implement FSM states IDLE, ADD, NORM, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on in_valid & in_ready, SHALL register all inputs and go to ADD.
REQ-019 Effective subtract SHALL be sign1 ^ sign2 ^ op.
REQ-020 Result sign SHALL be sign1 when sel=1, otherwise sign2 ^ op.
REQ-021 ADD, one cycle: SHALL form 25-bit sum = nonshifted_val + shifted_val (effective add) or nonshifted_val - shifted_val (effective subtract). Behaviour is undefined if shifted_val > nonshifted_val.
REQ-022 ADD, zero sum: result SHALL be 32'h0000_0000 (positive zero), then DONE.
REQ-023 ADD, sum[24]=1: mantissa SHALL be sum[24:1] (truncated) and exponent SHALL increment. If the new exponent equals 8'hFF: result = {sign, 8'hFF, 23'b0}, overflow=1. Then DONE.
REQ-024 ADD, sum[23]=1: result SHALL be packed directly, then DONE.
REQ-025 ADD, otherwise: SHALL go to NORM.
REQ-026 NORM, each cycle, exponent == 1: underflow SHALL be set to 1 and the block goes to DONE. If FLUSH_UNDERFLOW=1, result = {sign, 31'b0}; otherwise result = {sign, 8'h00, mant[22:0]}.
REQ-027 NORM, each cycle, otherwise: mantissa SHALL shift left 1 and exponent SHALL decrement 1. When the new mant[23]=1, the block packs the result and goes to DONE.
REQ-028 Latency, accept edge to out_valid: 2 cycles without normalization shift; 2 + n cycles with n NORM shifts; maximum 25.
REQ-029 DONE: out_valid SHALL be 1, and result and flags SHALL be stable while out_ready=0.
REQ-030 On out_valid & out_ready, SHALL return to IDLE. in_ready SHALL rise on the next cycle; a new accept SHALL NOT occur in the handshake cycle.
REQ-031 Rounding SHALL be truncation only; inputs with exponent 0 (denormals) are not supported.
REQ-032 Flags SHALL clear on each new accept.

Reset
REQ-033 While rstn=1 at a clock edge, the block SHALL go to IDLE with out_valid=0, result=0, overflow=0, underflow=0, and all internal registers 0.
REQ-034 in_ready SHALL be 0 during reset and 1 in the first cycle after rstn falls.
REQ-035 Reset during ADD, NORM or DONE SHALL abort the operation with no output handshake.

Structure
REQ-036 Shared package fp_pkg SHALL hold the state enum, MANT_W=24, EXP_W=8, EXP_MAX=8'hFF and the result-packing typedef.
REQ-037 The 25-bit add/subtract SHALL be sub-module mant_addsub (A, B, sub, S).

Verification
REQ-038 1.0+1.0: both mantissas 0x800000, exp=127, sel=1, signs 0, op=0 -> result 0x40000000, out_valid 2 cycles after accept.
REQ-039 1.5-1.0: nonshifted 0xC00000, shifted 0x800000, exp=127, op=1 -> result 0x3F000000 after 1 NORM cycle (latency 3).
REQ-040 x-x: equal mantissas 0x800000, exp=130, op=1 -> result 0x00000000, latency 2, no flags.
REQ-041 Overflow: exp=254, both 0xFFFFFF, add -> result 0x7F800000, overflow=1.
REQ-042 Underflow: exp=1, nonshifted 0x800000, shifted 0x7FFFFF, op=1 -> underflow=1, result 0x00000000.
REQ-043 Backpressure and reset: hold out_ready=0 for 5 cycles -> result stable; rstn=1 during NORM -> out_valid stays 0 and in_ready=1 in the cycle after rstn falls.
